inst_loader: RTL
================

INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, word-address width of the target instruction memory (depth 2**ADDR_WIDTH words).
REQ-002 clock  input  1  single clock; all state updates on posedge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-005 word_count  input  ADDR_WIDTH+1  number of words to load; sampled with start.
REQ-006 byte_in  input  8  incoming program byte.
REQ-007 byte_valid  input  1  byte_in valid this cycle.
REQ-008 byte_ready  output  1  loader accepts byte_in this cycle.
REQ-009 wr_en  output  1  one-cycle instruction-memory write strobe.
REQ-010 wr_addr  output  32  byte address of write; bits [1:0] always 0; bits [31:ADDR_WIDTH+2] always 0.
REQ-011 wr_data  output  32  word to write, in memory storage byte order.
REQ-012 busy  output  1  high from accepted start until done pulse inclusive.
REQ-013 done  output  1  one-cycle pulse when final word written.
REQ-014 error  output  1  one-cycle pulse when start rejected.
REQ-015 checksum  output  8  running sum mod 256 of all accepted bytes of current/last load.

Function
REQ-016 States: IDLE, COLLECT, WRITE, DONE; encoding free.
REQ-017 Byte accepted iff byte_valid && byte_ready at posedge; byte_ready = 1 only in COLLECT, combinational from state only (no dependence on byte_valid).
REQ-018 IDLE + start with 1 <= word_count <= 2**ADDR_WIDTH -> COLLECT next cycle; word index, byte counter, checksum cleared to 0; busy = 1 from that cycle.
REQ-019 IDLE + start with word_count == 0 or > 2**ADDR_WIDTH -> error = 1 next cycle, stay IDLE, checksum unchanged.
REQ-020 start outside IDLE ignored; no effect on any output.
REQ-021 Byte packing: 1st accepted byte of a word -> wr_data[7:0], 2nd -> [15:8], 3rd -> [23:16], 4th -> [31:24]; so fetch-side byte flip yields 1st stream byte as instruction[31:24].
REQ-022 4th byte accepted -> WRITE next cycle; byte_ready = 0 in WRITE.
REQ-023 WRITE lasts exactly one cycle: wr_en = 1, wr_addr = word_index * 4, wr_data = assembled word.
REQ-024 After WRITE: word_index increments; if new index == word_count -> DONE, else -> COLLECT.
REQ-025 DONE lasts one cycle: done = 1, busy = 1; then IDLE, busy = 0.
REQ-026 Throughput: min 5 cycles per word (4 accept + 1 write); byte_valid gaps stall without loss.
REQ-027 wr_en = 0 in every state except WRITE; wr_addr/wr_data hold last written values outside WRITE.
REQ-028 checksum updates on each accepted byte (8-bit wrap), holds through DONE/IDLE until next accepted start.
REQ-029 word_count == 2**ADDR_WIDTH: last write at wr_addr = (2**ADDR_WIDTH - 1) * 4; index never wraps into address 0.
REQ-030 byte_in ignored when byte_ready = 0 (no accept, no checksum change).

Reset
REQ-031 reset overrides all inputs, including mid-load: next state IDLE; byte_ready, wr_en, busy, done, error = 0; wr_addr, wr_data, checksum = 0; partial word discarded.
REQ-032 First start is sampled the cycle after reset deasserts.

Verification
REQ-033 start, word_count=1, bytes 0x3C,0x08,0x00,0x01 back-to-back -> one wr_en, wr_addr=0x0, wr_data=0x0100083C, checksum=0x45, done pulse 6 cycles after start.
REQ-034 word_count=3, byte_valid toggling every other cycle -> wr_addr 0x0,0x4,0x8 in order, no lost bytes, exactly 3 wr_en pulses, busy low after done.
REQ-035 start with word_count=0 and with word_count=257 (ADDR_WIDTH=8) -> error pulse each, busy stays 0, no wr_en.
REQ-036 word_count=256, 1024 bytes of 0xFF -> last wr_addr=0x3FC, wr_data=0xFFFFFFFF, checksum=0x00, no write at 0x0 after the first.
REQ-037 reset asserted after 2 bytes of word 1 -> all outputs 0 next cycle; fresh load afterwards writes word 0 at 0x0 from new bytes only.
REQ-038 start pulsed while in COLLECT -> ignored; word_count and checksum of active load unchanged.

Source files
------------

// File: rtl/inst_loader_if.sv
// Byte-stream load port and instruction-memory write port of the program loader.
interface inst_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic [ADDR_WIDTH:0]   word_count;
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  wr_en;
  logic [31:0]           wr_addr;
  logic [31:0]           wr_data;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [7:0]            checksum;

  modport master (
    output start, word_count, byte_in, byte_valid,
    input  byte_ready, wr_en, wr_addr, wr_data, busy, done, error, checksum
  );

  modport slave (
    input  start, word_count, byte_in, byte_valid,
    output byte_ready, wr_en, wr_addr, wr_data, busy, done, error, checksum
  );
endinterface

// File: rtl/inst_loader.sv
// Packs an incoming byte stream into 32-bit words (first byte in the low lane)
// and writes them to consecutive instruction-memory word addresses.
module inst_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic          clock_i,
  input  logic          reset_i,
  inst_loader_if.slave  bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_WRITE   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [1:0]            state_q,   state_d;
  logic [ADDR_WIDTH:0]   wcount_q,  wcount_d;
  logic [ADDR_WIDTH:0]   idx_q,     idx_d;
  logic [1:0]            bcnt_q,    bcnt_d;
  logic [23:0]           asm_q,     asm_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]           wr_data_q, wr_data_d;
  logic [7:0]            csum_q,    csum_d;
  logic                  error_q,   error_d;

  logic                  accept;
  logic                  count_ok;
  logic [ADDR_WIDTH:0]   idx_inc;

  assign accept   = (state_q == S_COLLECT) && bus.byte_valid;
  assign count_ok = (bus.word_count != '0) && (bus.word_count <= MAX_WORDS);
  assign idx_inc  = idx_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    wcount_d  = wcount_q;
    idx_d     = idx_q;
    bcnt_d    = bcnt_q;
    asm_d     = asm_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    csum_d    = csum_q;
    error_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (count_ok) begin
            state_d  = S_COLLECT;
            wcount_d = bus.word_count;
            idx_d    = '0;
            bcnt_d   = '0;
            csum_d   = '0;
          end else begin
            error_d  = 1'b1;
          end
        end
      end

      S_COLLECT: begin
        if (accept) begin
          csum_d = csum_q + bus.byte_in;
          bcnt_d = bcnt_q + 1'b1;
          case (bcnt_q)
            2'd0: asm_d[7:0]   = bus.byte_in;
            2'd1: asm_d[15:8]  = bus.byte_in;
            2'd2: asm_d[23:16] = bus.byte_in;
            default: begin
              // Write-port registers only change here so they hold between writes.
              wr_data_d = {bus.byte_in, asm_q};
              wr_addr_d = idx_q[ADDR_WIDTH-1:0];
              state_d   = S_WRITE;
            end
          endcase
        end
      end

      S_WRITE: begin
        idx_d   = idx_inc;
        state_d = (idx_inc == wcount_q) ? S_DONE : S_COLLECT;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      wcount_q  <= '0;
      idx_q     <= '0;
      bcnt_q    <= '0;
      asm_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      csum_q    <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcount_q  <= wcount_d;
      idx_q     <= idx_d;
      bcnt_q    <= bcnt_d;
      asm_q     <= asm_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      csum_q    <= csum_d;
      error_q   <= error_d;
    end
  end

  assign bus.byte_ready = (state_q == S_COLLECT);
  assign bus.wr_en      = (state_q == S_WRITE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.error      = error_q;
  assign bus.checksum   = csum_q;
  assign bus.wr_addr    = {{(30-ADDR_WIDTH){1'b0}}, wr_addr_q, 2'b00};
  assign bus.wr_data    = wr_data_q;

endmodule
